// File: rtl/pong_render.sv
// pong_render: one-player pong game state plus a two-stage pixel colour pipeline.
// Game state advances only on the vertical-blanking tick; colours and syncs lag the raster by two clocks.
module pong_render #(
    parameter int H_OFFSET    = 48,
    parameter int V_OFFSET    = 33,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int BALL_SPD    = 2,
    parameter int PAD_W       = 8,
    parameter int PAD_H       = 64,
    parameter int PAD_MARGIN  = 16,
    parameter int PAD_SPD     = 4,
    parameter int MISS_FRAMES = 60
) (
    input  logic       pix_clk,
    input  logic       rst_pix_n,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [3:0] score_l,
    output logic [3:0] score_r
);

    localparam int MW = $clog2(MISS_FRAMES + 1);

    localparam logic [9:0] L_TICK_Y    = 10'(V_OFFSET + V_ACTIVE);
    localparam logic [9:0] L_H_OFF     = 10'(H_OFFSET);
    localparam logic [9:0] L_V_OFF     = 10'(V_OFFSET);
    localparam logic [9:0] L_SERVE_X   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] L_SERVE_Y   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] L_PAD_INIT  = 10'((V_ACTIVE - PAD_H) / 2);
    localparam logic [9:0] L_PAD_MAX   = 10'(V_ACTIVE - PAD_H);
    localparam logic [9:0] L_PAD_SPD   = 10'(PAD_SPD);
    localparam logic [9:0] L_PAD_HM1   = 10'(PAD_H - 1);
    localparam logic [9:0] L_PAD_HALF  = 10'(PAD_H / 2);
    localparam logic [9:0] L_BALL_SPD  = 10'(BALL_SPD);
    localparam logic [9:0] L_BALL_M1   = 10'(BALL_SIZE - 1);
    localparam logic [9:0] L_BALL_HALF = 10'(BALL_SIZE / 2);
    localparam logic [9:0] L_BOT       = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] L_BOT_TURN  = 10'(V_ACTIVE - BALL_SIZE - BALL_SPD);
    localparam logic [9:0] L_PL_X0     = 10'(PAD_MARGIN);
    localparam logic [9:0] L_PL_X1     = 10'(PAD_MARGIN + PAD_W - 1);
    localparam logic [9:0] L_AI_X0     = 10'(H_ACTIVE - PAD_MARGIN - PAD_W);
    localparam logic [9:0] L_AI_X1     = 10'(H_ACTIVE - PAD_MARGIN - 1);
    localparam logic [9:0] L_L_ZONE    = 10'(PAD_MARGIN + PAD_W + BALL_SPD);
    localparam logic [9:0] L_L_HIT     = 10'(PAD_MARGIN + PAD_W);
    localparam logic [9:0] L_R_ZONE    = 10'(H_ACTIVE - PAD_MARGIN - PAD_W - BALL_SIZE - BALL_SPD);
    localparam logic [9:0] L_R_HIT     = 10'(H_ACTIVE - PAD_MARGIN - PAD_W - BALL_SIZE);
    localparam logic [9:0] L_R_MISS    = 10'(H_ACTIVE - BALL_SIZE - BALL_SPD);
    localparam logic [9:0] L_NET_X0    = 10'(H_ACTIVE / 2 - 1);
    localparam logic [9:0] L_NET_X1    = 10'(H_ACTIVE / 2);
    localparam logic [MW-1:0] L_MISS_LOAD = MW'(MISS_FRAMES - 1);

    // state   | meaning
    // S_SERVE | ball parked, re-centred on the next tick
    // S_PLAY  | ball moving, walls/paddles/misses evaluated each tick
    // S_MISS  | ball frozen, red background, r_miss_cnt counts down to serve
    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_MISS} state_t;

    state_t        r_state;
    logic [9:0]    r_bx;
    logic [9:0]    r_by;
    logic          r_dx;
    logic          r_dy;
    logic [9:0]    r_pl_y;
    logic [9:0]    r_ai_y;
    logic [MW-1:0] r_miss_cnt;
    logic [3:0]    r_score_l;
    logic [3:0]    r_score_r;

    logic          r_hit_ball;
    logic          r_hit_pl;
    logic          r_hit_ai;
    logic          r_hit_net;
    logic          r_de1;
    logic          r_hs1;
    logic          r_vs1;
    logic [3:0]    r_red;
    logic [3:0]    r_grn;
    logic [3:0]    r_blu;
    logic          r_de2;
    logic          r_hs2;
    logic          r_vs2;

    logic          w_tick;
    logic [9:0]    w_ax;
    logic [9:0]    w_ay;
    logic [9:0]    w_pl_next;
    logic [9:0]    w_ai_next;
    logic [9:0]    w_by_next;
    logic          w_dy_next;
    logic [9:0]    w_ball_c;
    logic [9:0]    w_ai_c;
    logic          w_pl_ovl;
    logic          w_ai_ovl;

    assign w_tick   = (sx == 10'd0) && (sy == L_TICK_Y);
    assign w_ax     = sx - L_H_OFF;
    assign w_ay     = sy - L_V_OFF;
    assign w_ball_c = r_by + L_BALL_HALF;
    assign w_ai_c   = r_ai_y + L_PAD_HALF;
    assign w_pl_ovl = (r_by <= r_pl_y + L_PAD_HM1) && (r_pl_y <= r_by + L_BALL_M1);
    assign w_ai_ovl = (r_by <= r_ai_y + L_PAD_HM1) && (r_ai_y <= r_by + L_BALL_M1);

    always_comb begin
        w_pl_next = r_pl_y;
        if (btn_up && !btn_dn)
            w_pl_next = (r_pl_y < L_PAD_SPD) ? 10'd0 : r_pl_y - L_PAD_SPD;
        else if (btn_dn && !btn_up)
            w_pl_next = (r_pl_y + L_PAD_SPD > L_PAD_MAX) ? L_PAD_MAX : r_pl_y + L_PAD_SPD;

        // AI only reacts once the centres are more than one step apart, so it does not jitter
        w_ai_next = r_ai_y;
        if (w_ball_c > w_ai_c + L_PAD_SPD)
            w_ai_next = (r_ai_y + L_PAD_SPD > L_PAD_MAX) ? L_PAD_MAX : r_ai_y + L_PAD_SPD;
        else if (w_ball_c + L_PAD_SPD < w_ai_c)
            w_ai_next = (r_ai_y < L_PAD_SPD) ? 10'd0 : r_ai_y - L_PAD_SPD;

        w_by_next = r_by;
        w_dy_next = r_dy;
        if (r_dy) begin
            if (r_by >= L_BOT_TURN) begin
                w_by_next = L_BOT;
                w_dy_next = 1'b0;
            end else begin
                w_by_next = r_by + L_BALL_SPD;
            end
        end else begin
            if (r_by < L_BALL_SPD) begin
                w_by_next = 10'd0;
                w_dy_next = 1'b1;
            end else begin
                w_by_next = r_by - L_BALL_SPD;
            end
        end
    end

    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_state    <= S_SERVE;
            r_bx       <= L_SERVE_X;
            r_by       <= L_SERVE_Y;
            r_dx       <= 1'b0;
            r_dy       <= 1'b1;
            r_pl_y     <= L_PAD_INIT;
            r_ai_y     <= L_PAD_INIT;
            r_miss_cnt <= '0;
            r_score_l  <= 4'd0;
            r_score_r  <= 4'd0;
        end else if (w_tick) begin
            r_pl_y <= w_pl_next;
            r_ai_y <= w_ai_next;
            unique case (r_state)
                S_SERVE: begin
                    r_bx    <= L_SERVE_X;
                    r_by    <= L_SERVE_Y;
                    r_dy    <= 1'b1;
                    r_state <= S_PLAY;
                end
                S_PLAY: begin
                    r_by <= w_by_next;
                    r_dy <= w_dy_next;
                    if (!r_dx && (r_bx < L_L_ZONE) && w_pl_ovl) begin
                        r_bx <= L_L_HIT;
                        r_dx <= 1'b1;
                    end else if (!r_dx && (r_bx < L_BALL_SPD)) begin
                        if (r_score_r != 4'hF)
                            r_score_r <= r_score_r + 4'd1;
                        r_dx       <= 1'b0;
                        r_state    <= S_MISS;
                        r_miss_cnt <= L_MISS_LOAD;
                    end else if (r_dx && (r_bx > L_R_ZONE) && w_ai_ovl) begin
                        r_bx <= L_R_HIT;
                        r_dx <= 1'b0;
                    end else if (r_dx && (r_bx > L_R_MISS)) begin
                        if (r_score_l != 4'hF)
                            r_score_l <= r_score_l + 4'd1;
                        r_dx       <= 1'b1;
                        r_state    <= S_MISS;
                        r_miss_cnt <= L_MISS_LOAD;
                    end else if (r_dx) begin
                        r_bx <= r_bx + L_BALL_SPD;
                    end else begin
                        r_bx <= r_bx - L_BALL_SPD;
                    end
                end
                S_MISS: begin
                    if (r_miss_cnt == '0)
                        r_state <= S_SERVE;
                    else
                        r_miss_cnt <= r_miss_cnt - 1'b1;
                end
                default: r_state <= S_SERVE;
            endcase
        end
    end

    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_hit_ball <= 1'b0;
            r_hit_pl   <= 1'b0;
            r_hit_ai   <= 1'b0;
            r_hit_net  <= 1'b0;
            r_de1      <= 1'b0;
            r_hs1      <= 1'b1;
            r_vs1      <= 1'b1;
        end else begin
            r_hit_ball <= (w_ax >= r_bx) && (w_ax <= r_bx + L_BALL_M1) &&
                          (w_ay >= r_by) && (w_ay <= r_by + L_BALL_M1);
            r_hit_pl   <= (w_ax >= L_PL_X0) && (w_ax <= L_PL_X1) &&
                          (w_ay >= r_pl_y) && (w_ay <= r_pl_y + L_PAD_HM1);
            r_hit_ai   <= (w_ax >= L_AI_X0) && (w_ax <= L_AI_X1) &&
                          (w_ay >= r_ai_y) && (w_ay <= r_ai_y + L_PAD_HM1);
            r_hit_net  <= ((w_ax == L_NET_X0) || (w_ax == L_NET_X1)) && !w_ay[3];
            r_de1      <= de;
            r_hs1      <= hsync;
            r_vs1      <= vsync;
        end
    end

    always_ff @(posedge pix_clk or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_red <= 4'h0;
            r_grn <= 4'h0;
            r_blu <= 4'h0;
            r_de2 <= 1'b0;
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
        end else begin
            r_de2 <= r_de1;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            if (!r_de1) begin
                {r_red, r_grn, r_blu} <= 12'h000;
            end else if (r_hit_ball || r_hit_pl || r_hit_ai) begin
                {r_red, r_grn, r_blu} <= 12'hFFF;
            end else if (r_hit_net) begin
                {r_red, r_grn, r_blu} <= 12'h888;
            end else if (r_state == S_MISS) begin
                {r_red, r_grn, r_blu} <= 12'h400;
            end else begin
                {r_red, r_grn, r_blu} <= 12'h002;
            end
        end
    end

    assign r       = r_red;
    assign g       = r_grn;
    assign b       = r_blu;
    assign de_o    = r_de2;
    assign hsync_o = r_hs2;
    assign vsync_o = r_vs2;
    assign score_l = r_score_l;
    assign score_r = r_score_r;

endmodule

// File: tb/tb_pong_render.sv
// tb_pong_render: random raster probes and button patterns checked against a frame-level pong model.
module tb_pong_render;

    logic       pix_clk = 1'b0;
    logic       rst_pix_n;
    logic [9:0] sx, sy;
    logic       de, hsync, vsync, btn_up, btn_dn;
    logic [3:0] r, g, b, score_l, score_r;
    logic       de_o, hsync_o, vsync_o;

    always #5 pix_clk = ~pix_clk;

    pong_render dut (
        .pix_clk  (pix_clk),
        .rst_pix_n(rst_pix_n),
        .sx       (sx),
        .sy       (sy),
        .de       (de),
        .hsync    (hsync),
        .vsync    (vsync),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .r        (r),
        .g        (g),
        .b        (b),
        .de_o     (de_o),
        .hsync_o  (hsync_o),
        .vsync_o  (vsync_o),
        .score_l  (score_l),
        .score_r  (score_r)
    );

    localparam logic [14:0] RST_PIX = 15'h0003;

    int n_checks = 0;
    int n_errors = 0;

    // frame-level game model: 0 serve, 1 play, 2 miss; dx/dy are +1/-1
    int m_state, m_bx, m_by, m_dx, m_dy, m_pl, m_ai, m_miss, m_sl, m_sr;
    logic [14:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_bx = 316; m_by = 236; m_dx = -1; m_dy = 1;
        m_pl = 208; m_ai = 208; m_miss = 0; m_sl = 0; m_sr = 0;
    endfunction

    function automatic bit spans_overlap(int ball_top, int pad_top);
        return (ball_top <= pad_top + 63) && (pad_top <= ball_top + 7);
    endfunction

    function automatic int clamp_pad(int y);
        if (y < 0) return 0;
        if (y > 416) return 416;
        return y;
    endfunction

    function automatic void model_tick(bit up, bit dn);
        int npl, nai, gap, ny, ndy;
        npl = m_pl;
        if (up && !dn) npl = clamp_pad(m_pl - 4);
        if (dn && !up) npl = clamp_pad(m_pl + 4);
        gap = (m_by + 4) - (m_ai + 32);
        nai = m_ai;
        if (gap > 4)  nai = clamp_pad(m_ai + 4);
        if (gap < -4) nai = clamp_pad(m_ai - 4);
        case (m_state)
            0: begin
                m_bx = 316; m_by = 236; m_dy = 1; m_state = 1;
            end
            1: begin
                ny = m_by + 2 * m_dy;
                ndy = m_dy;
                if (m_dy > 0 && m_by + 10 >= 480) begin ny = 472; ndy = -1; end
                if (m_dy < 0 && m_by < 2) begin ny = 0; ndy = 1; end
                if (m_dx < 0 && m_bx < 26 && spans_overlap(m_by, m_pl)) begin
                    m_bx = 24; m_dx = 1;
                end else if (m_dx < 0 && m_bx < 2) begin
                    m_sr = (m_sr >= 15) ? 15 : m_sr + 1; m_state = 2; m_miss = 0;
                end else if (m_dx > 0 && m_bx + 10 > 616 && spans_overlap(m_by, m_ai)) begin
                    m_bx = 608; m_dx = -1;
                end else if (m_dx > 0 && m_bx + 10 > 640) begin
                    m_sl = (m_sl >= 15) ? 15 : m_sl + 1; m_state = 2; m_miss = 0;
                end else begin
                    m_bx = m_bx + 2 * m_dx;
                end
                m_by = ny; m_dy = ndy;
            end
            default: begin
                m_miss++;
                if (m_miss == 60) begin m_state = 0; m_miss = 0; end
            end
        endcase
        m_pl = npl; m_ai = nai;
    endfunction

    function automatic logic [14:0] exp_pix(int x, int y, bit d, bit h, bit v);
        int ax, ay;
        logic [11:0] c;
        ax = (x - 48) & 1023;
        ay = (y - 33) & 1023;
        if (!d)
            c = 12'h000;
        else if (ax >= m_bx && ax < m_bx + 8 && ay >= m_by && ay < m_by + 8)
            c = 12'hFFF;
        else if ((ax >= 16 && ax < 24 && ay >= m_pl && ay < m_pl + 64) ||
                 (ax >= 616 && ax < 624 && ay >= m_ai && ay < m_ai + 64))
            c = 12'hFFF;
        else if ((ax == 319 || ax == 320) && (ay % 16) < 8)
            c = 12'h888;
        else
            c = (m_state == 2) ? 12'h400 : 12'h002;
        return {c, d, h, v};
    endfunction

    // one raster cycle: check the output due from two cycles ago, then present new inputs
    task automatic drive(input int x, input int y, input bit d);
        bit h, v;
        @(negedge pix_clk);
        if (exp_q.size() == 2)
            check_val("pixel", {17'd0, r, g, b, de_o, hsync_o, vsync_o}, {17'd0, exp_q.pop_front()});
        h = 1'($urandom_range(0, 1));
        v = 1'($urandom_range(0, 1));
        sx = 10'(x); sy = 10'(y); de = d; hsync = h; vsync = v;
        exp_q.push_back(exp_pix(x, y, d, h, v));
        if (x == 0 && y == 513) model_tick(btn_up, btn_dn);
    endtask

    task automatic probe_random();
        int x, y;
        x = int'($urandom_range(0, 799));
        y = int'($urandom_range(0, 524));
        if (x == 0 && y == 513) y = 512;
        drive(x, y, 1'($urandom_range(0, 1)));
    endtask

    task automatic probe_target();
        int ax, ay;
        case ($urandom_range(0, 19))
            0:  begin ax = m_bx;     ay = m_by;     end
            1:  begin ax = m_bx + 7; ay = m_by + 7; end
            2:  begin ax = m_bx - 1; ay = m_by + 3; end
            3:  begin ax = m_bx + 8; ay = m_by + 3; end
            4:  begin ax = m_bx + 3; ay = m_by - 1; end
            5:  begin ax = m_bx + 3; ay = m_by + 8; end
            6:  begin ax = 16;  ay = m_pl;      end
            7:  begin ax = 23;  ay = m_pl + 63; end
            8:  begin ax = 15;  ay = m_pl + 5;  end
            9:  begin ax = 20;  ay = m_pl - 1;  end
            10: begin ax = 20;  ay = m_pl + 64; end
            11: begin ax = 616; ay = m_ai;      end
            12: begin ax = 623; ay = m_ai + 63; end
            13: begin ax = 624; ay = m_ai + 5;  end
            14: begin ax = 620; ay = m_ai + 64; end
            15: begin ax = 319; ay = int'($urandom_range(0, 479)); end
            16: begin ax = 320; ay = int'($urandom_range(0, 479)); end
            17: begin ax = 321; ay = int'($urandom_range(0, 479)); end
            18: begin ax = 318; ay = int'($urandom_range(0, 479)); end
            default: begin ax = int'($urandom_range(0, 639)); ay = int'($urandom_range(0, 479)); end
        endcase
        drive((ax + 48) & 1023, (ay + 33) & 1023, 1'b1);
    endtask

    task automatic frame(input bit up, input bit dn);
        btn_up = up; btn_dn = dn;
        drive(0, 513, 1'b0);
        probe_target();
        check_val("score_l", {28'd0, score_l}, m_sl);
        check_val("score_r", {28'd0, score_r}, m_sr);
        for (int i = 0; i < 4; i++) probe_target();
        probe_random();
    endtask

    task automatic release_reset();
        @(negedge pix_clk);
        rst_pix_n = 1'b1;
        model_reset();
        exp_q.delete();
        exp_q.push_back(RST_PIX);
        exp_q.push_back(exp_pix(int'(sx), int'(sy), de, hsync, vsync));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val(tag, {17'd0, r, g, b, de_o, hsync_o, vsync_o}, {17'd0, RST_PIX});
        check_val({tag, "_scores"}, {24'd0, score_l, score_r}, 32'd0);
    endtask

    initial begin
        int extra;
        rst_pix_n = 1'b0;
        sx = 10'd100; sy = 10'd100; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
        btn_up = 1'b0; btn_dn = 1'b0;
        model_reset();
        @(negedge pix_clk);
        check_reset_outputs("reset");
        release_reset();

        frame(1'b0, 1'b0);
        drive(364, 269, 1'b1);
        drive(48, 33, 1'b1);
        drive(100, 100, 1'b0);
        drive(400, 200, 1'b1);

        for (int i = 0; i < 60; i++)  frame(1'b1, 1'b0);
        for (int i = 0; i < 120; i++) frame(1'b0, 1'b1);
        for (int i = 0; i < 10; i++)  frame(1'b1, 1'b1);
        for (int i = 0; i < 200; i++)
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        extra = 0;
        for (int i = 0; i < 4200 && extra < 260; i++) begin
            frame(1'b1, 1'b0);
            if (m_sr == 15) extra++;
        end

        drive(300, 150, 1'b1);
        @(negedge pix_clk);
        rst_pix_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge pix_clk);
        release_reset();
        for (int i = 0; i < 40; i++)
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive(200, 200, 1'b0);
        drive(200, 200, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
